// File: rtl/object_datapath.sv
// object_datapath: position/direction registers for a bouncing box plus a
// one-pixel-per-cycle sprite scanner that feeds a VGA adapter.
module object_datapath #(
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter int          BOX       = 4,
  parameter int          X_INIT    = 0,
  parameter int          Y_INIT    = 60,
  parameter logic [2:0]  DRAW_COL  = 3'b111,
  parameter logic [2:0]  ERASE_COL = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       move_en,
  input  logic       load_coord,
  input  logic       datapath_en,
  input  logic       plot,
  input  logic [1:0] op,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       done,
  output logic       touch_edge
);

  localparam int             NPIX  = BOX * BOX;
  localparam int             CW    = $clog2(NPIX);
  localparam int             HW    = CW / 2;
  localparam logic [CW-1:0]  LAST  = CW'(NPIX - 1);
  localparam logic [7:0]     X_MAX = 8'(SCREEN_W - BOX);
  localparam logic [6:0]     Y_MAX = 7'(SCREEN_H - BOX);

  // Direction after a step: bounce off a border, otherwise keep going.
  // dir = 1 means increasing coordinate (right / down).
  function automatic logic next_dir_x(input logic [7:0] p, input logic d);
    if (p == 8'd0)       return 1'b1;
    else if (p == X_MAX) return 1'b0;
    else                 return d;
  endfunction

  function automatic logic next_dir_y(input logic [6:0] p, input logic d);
    if (p == 7'd0)       return 1'b1;
    else if (p == Y_MAX) return 1'b0;
    else                 return d;
  endfunction

  logic [7:0]    pos_x_q, pos_x_d;
  logic [6:0]    pos_y_q, pos_y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    col_q, col_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          touch_q, touch_d;

  logic [HW-1:0] scan_col;
  logic [HW-1:0] scan_row;
  logic          step;

  assign scan_col = cnt_q[HW-1:0];
  assign scan_row = cnt_q[CW-1:HW];
  // Motion is only allowed between scans so draw/erase always match.
  assign step     = load_coord & armed_q & ~datapath_en;

  // Next-state for the pixel scanner and VGA outputs.
  always_comb begin
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    col_d  = col_q;
    we_d   = 1'b0;
    done_d = 1'b0;
    if (datapath_en) begin
      x_d  = pos_x_q + {{(8 - HW){1'b0}}, scan_col};
      y_d  = pos_y_q + {{(7 - HW){1'b0}}, scan_row};
      case (op)
        2'b00:   col_d = DRAW_COL;
        2'b01:   col_d = ERASE_COL;
        default: col_d = col_q;
      endcase
      we_d   = plot & ~op[1];
      done_d = (cnt_q == LAST);
      cnt_d  = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Next-state for position, direction, arming and border detection.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    armed_d = move_en | (armed_q & ~step);
    touch_d = (pos_x_q == 8'd0) | (pos_x_q == X_MAX) |
              (pos_y_q == 7'd0) | (pos_y_q == Y_MAX);
    if (step) begin
      dir_x_d = next_dir_x(pos_x_q, dir_x_q);
      dir_y_d = next_dir_y(pos_y_q, dir_y_q);
      pos_x_d = dir_x_d ? pos_x_q + 8'd1 : pos_x_q - 8'd1;
      pos_y_d = dir_y_d ? pos_y_q + 7'd1 : pos_y_q - 7'd1;
    end
  end

  // State register; reset clears the scan and returns the box home.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q <= 8'(X_INIT);
      pos_y_q <= 7'(Y_INIT);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      touch_q <= 1'b0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      we_q    <= we_d;
      done_q  <= done_d;
      touch_q <= touch_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour     = col_q;
  assign writeEn    = we_q;
  assign done       = done_q;
  assign touch_edge = touch_q;

endmodule
